priority_decoder_dectobin_rx: RTL and testbench

//  Inverse of the 10-input priority encoder: accepts a 4-bit binary index plus valid and regenerates
//  the 10-bit one-hot decimal line vector. Registered single-stage pipeline with valid/ready on both sides.

---
 rtl/prio_enc_pkg.sv | 15 +
 rtl/prio_dec_hit_cnt.sv | 39 +++
 rtl/priority_decoder_dectobin_rx.sv | 91 +++++++++
 tb/tb_priority_decoder_dectobin_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the 10-line priority encoder/decoder pair.
// Used by the encoder side as well as by priority_decoder_dectobin_rx.
package prio_enc_pkg;

  localparam int DEC_N_OUT  = 10;
  localparam int DEC_CODE_W = 4;

  function automatic logic code_legal(
    input int code,
    input int n_out = DEC_N_OUT
  );
    return code < n_out;
  endfunction

endpackage

// File: rtl/prio_dec_hit_cnt.sv
// Per-line saturating hit counters for the one-hot decoder.
// Built only when PRIO_DEC_HIT_CNT_EN is defined.
module prio_dec_hit_cnt
  import prio_enc_pkg::*;
#(
  parameter int N_OUT  = DEC_N_OUT,
  parameter int CODE_W = DEC_CODE_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hit,
  input  logic [N_OUT-1:0]  i_onehot,
  input  logic [CODE_W-1:0] i_rd_sel,
  output logic [CNT_W-1:0]  o_rd_cnt
);

  logic [CNT_W-1:0] r_cnt [N_OUT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (i_hit && i_onehot[i] && (r_cnt[i] != '1))
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Selects outside the line range fall through to zero.
  always_comb begin
    o_rd_cnt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (i_rd_sel == CODE_W'(i)) o_rd_cnt = r_cnt[i];
    end
  end

endmodule

// File: rtl/priority_decoder_dectobin_rx.sv
// Registered binary-index to one-hot decoder with valid/ready and error capture.
// Optional hit counters: define PRIO_DEC_HIT_CNT_EN.
module priority_decoder_dectobin_rx
  import prio_enc_pkg::*;
#(
  parameter int N_OUT  = DEC_N_OUT,
  parameter int CODE_W = DEC_CODE_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N_OUT-1:0]  out_onehot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err,
  output logic [CODE_W-1:0] err_code,
  input  logic              err_clr
`ifdef PRIO_DEC_HIT_CNT_EN
  ,
  input  logic [CODE_W-1:0] rd_sel,
  output logic [CNT_W-1:0]  rd_cnt
`endif
);

  logic              r_valid;
  logic [N_OUT-1:0]  r_onehot;
  logic              r_err;
  logic [CODE_W-1:0] r_err_code;

  logic              w_accept;
  logic              w_legal;
  logic [N_OUT-1:0]  w_dec;

  assign in_ready   = !r_valid | out_ready;
  assign w_accept   = in_valid & in_ready;
  assign w_legal    = code_legal(int'(in_code), N_OUT);
  assign w_dec      = N_OUT'(1) << in_code;

  assign out_valid  = r_valid;
  assign out_onehot = r_onehot;
  assign err        = r_err;
  assign err_code   = r_err_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_onehot <= '0;
    end else if (w_accept && w_legal) begin
      r_valid  <= 1'b1;
      r_onehot <= w_dec;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
      r_onehot <= '0;
    end
  end

  // A new illegal code beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_code <= in_code;
    end else if (err_clr) begin
      r_err      <= 1'b0;
      r_err_code <= '0;
    end
  end

`ifdef PRIO_DEC_HIT_CNT_EN
  prio_dec_hit_cnt #(
    .N_OUT  (N_OUT),
    .CODE_W (CODE_W),
    .CNT_W  (CNT_W)
  ) u_hit_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_hit    (r_valid & out_ready),
    .i_onehot (r_onehot),
    .i_rd_sel (rd_sel),
    .o_rd_cnt (rd_cnt)
  );
`else
  // Base build: no counter bank.
`endif

endmodule

// File: tb/tb_priority_decoder_dectobin_rx.sv
// Self-checking bench for priority_decoder_dectobin_rx.
// Define PRIO_DEC_HIT_CNT_EN to also exercise the hit counters.
module tb_priority_decoder_dectobin_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_code;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] out_onehot;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [3:0] err_code;
  logic       err_clr;
`ifdef PRIO_DEC_HIT_CNT_EN
  logic [3:0] rd_sel;
  logic [7:0] rd_cnt;
`endif

  int checks = 0;
  int errors = 0;

  int m_held;
  bit m_err;
  int m_ecode;
  int m_hits [10];

  always #5 clk = ~clk;

  priority_decoder_dectobin_rx dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err),
    .err_code   (err_code),
    .err_clr    (err_clr)
`ifdef PRIO_DEC_HIT_CNT_EN
    ,
    .rd_sel     (rd_sel),
    .rd_cnt     (rd_cnt)
`endif
  );

  function automatic logic [9:0] exp_oh();
    if (m_held < 0) return 10'd0;
    return 10'(2 ** m_held);
  endfunction

  task automatic model_reset();
    m_held  = -1;
    m_err   = 0;
    m_ecode = 0;
    for (int i = 0; i < 10; i++) m_hits[i] = 0;
  endtask

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input int c, input bit v, input bit r, input bit clr);
    bit rdy;
    bit acc;
    @(negedge clk);
    in_code   = 4'(c);
    in_valid  = v;
    out_ready = r;
    err_clr   = clr;
    rdy = (m_held < 0) || r;
    acc = v && rdy;
    if (m_held >= 0 && r && m_hits[m_held] < 255) m_hits[m_held]++;
    if (acc && c < 10) m_held = c;
    else if (r) m_held = -1;
    if (acc && c >= 10) begin
      if (!m_err || clr) m_ecode = c;
      m_err = 1;
    end else if (clr) begin
      m_err   = 0;
      m_ecode = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_onehot !== 10'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b oh=%h want v=0 oh=000", out_valid, out_onehot);
    end
    checks++;
    if (err !== 1'b0 || err_code !== 4'd0) begin
      errors++;
      $display("FAIL reset_err got err=%b code=%0d want 0/0", err, err_code);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    // Build up state, then reset asynchronously mid-hold.
    step(13, 1, 1, 0);
    step(4, 1, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got v=%b err=%b want 1/1", out_valid, err);
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_onehot !== 10'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b oh=%h err=%b want 0/000/0",
               out_valid, out_onehot, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    step(7, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_onehot !== 10'b0010000000) begin
      errors++;
      $display("FAIL single_7 got v=%b oh=%b want 1/0010000000", out_valid, out_onehot);
    end
    step(0, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_onehot !== 10'd0) begin
      errors++;
      $display("FAIL drain got v=%b oh=%h want 0/000", out_valid, out_onehot);
    end
  endtask

  task automatic test_hold();
    step(3, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(9, 1, 0, 0);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 10'h008) begin
        errors++;
        $display("FAIL hold_%0d got rdy=%b v=%b oh=%h want 0/1/008",
                 k, in_ready, out_valid, out_onehot);
      end
    end
    step(9, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_onehot !== 10'h200) begin
      errors++;
      $display("FAIL hold_release got v=%b oh=%h want 1/200", out_valid, out_onehot);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_illegal();
    step(12, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1 || err_code !== 4'd12) begin
      errors++;
      $display("FAIL illegal_12 got v=%b err=%b code=%0d want 0/1/12",
               out_valid, err, err_code);
    end
    step(15, 1, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || err !== 1'b1 || err_code !== 4'd12) begin
      errors++;
      $display("FAIL illegal_15 got v=%b err=%b code=%0d want 0/1/12",
               out_valid, err, err_code);
    end
    step(10, 1, 1, 1);
    checks++;
    if (err !== 1'b1 || err_code !== 4'd10) begin
      errors++;
      $display("FAIL clr_vs_err got err=%b code=%0d want 1/10", err, err_code);
    end
    step(0, 0, 1, 1);
    checks++;
    if (err !== 1'b0 || err_code !== 4'd0) begin
      errors++;
      $display("FAIL clr got err=%b code=%0d want 0/0", err, err_code);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    int tokens = 0;
    for (int i = 0; i < 10; i++) begin
      step(i, 1, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_onehot !== 10'(2 ** i)) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b oh=%b", i, out_valid, out_onehot);
      end else begin
        tokens++;
      end
    end
    checks++;
    if (tokens != 10) begin
      errors++;
      $display("FAIL b2b_throughput got %0d tokens want 10", tokens);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_random();
    int c;
    bit v, r, clr;
    for (int n = 0; n < 400; n++) begin
      c   = int'($urandom_range(0, 15));
      v   = $urandom_range(0, 3) != 0;
      r   = $urandom_range(0, 3) != 0;
      clr = $urandom_range(0, 15) == 0;
      step(c, v, r, clr);
      checks++;
      if (out_valid !== (m_held >= 0) || out_onehot !== exp_oh() ||
          err !== m_err || err_code !== 4'(m_ecode) ||
          in_ready !== ((m_held < 0) || r)) begin
        errors++;
        $display("FAIL rand_%0d got v=%b oh=%h err=%b code=%0d rdy=%b want v=%b oh=%h err=%b code=%0d",
                 n, out_valid, out_onehot, err, err_code, in_ready,
                 m_held >= 0, exp_oh(), m_err, m_ecode);
      end
      checks++;
      if ($countones(out_onehot) != int'(out_valid)) begin
        errors++;
        $display("FAIL rand_popcount got %0d want %0d", $countones(out_onehot), out_valid);
      end
    end
    step(0, 0, 1, 0);
  endtask

`ifdef PRIO_DEC_HIT_CNT_EN
  task automatic test_hit_cnt();
    do_reset();
    for (int n = 0; n < 300; n++) step(5, 1, 1, 0);
    step(0, 0, 1, 0);
    rd_sel = 4'd5;
    #1;
    checks++;
    if (rd_cnt !== 8'(m_hits[5]) || rd_cnt !== 8'd255) begin
      errors++;
      $display("FAIL hit_5 got %0d want %0d", rd_cnt, m_hits[5]);
    end
    rd_sel = 4'd4;
    #1;
    checks++;
    if (rd_cnt !== 8'(m_hits[4])) begin
      errors++;
      $display("FAIL hit_4 got %0d want %0d", rd_cnt, m_hits[4]);
    end
    rd_sel = 4'd11;
    #1;
    checks++;
    if (rd_cnt !== 8'd0) begin
      errors++;
      $display("FAIL hit_11 got %0d want 0", rd_cnt);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_code   = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
`ifdef PRIO_DEC_HIT_CNT_EN
    rd_sel    = 4'd0;
`endif
    model_reset();
    test_reset();
    test_single();
    test_hold();
    test_illegal();
    test_back_to_back();
    test_random();
`ifdef PRIO_DEC_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
